// File: rtl/alu_seq_pkg.sv
// Shared definitions for the DLX execute-stage ALU control unit and its mul/div sequencer.
// Optional feature macro: ALU_SEQ_DIV_EN (enables DIV/DIVU).
package alu_seq_pkg;

    localparam logic [3:0] CTR_AND  = 4'd0;
    localparam logic [3:0] CTR_OR   = 4'd1;
    localparam logic [3:0] CTR_ADD  = 4'd2;
    localparam logic [3:0] CTR_SLT  = 4'd3;
    localparam logic [3:0] CTR_XOR  = 4'd4;
    localparam logic [3:0] CTR_SLL  = 4'd5;
    localparam logic [3:0] CTR_SUB  = 4'd6;
    localparam logic [3:0] CTR_SLTU = 4'd7;
    localparam logic [3:0] CTR_ADDU = 4'd8;
    localparam logic [3:0] CTR_SUBU = 4'd9;
    localparam logic [3:0] CTR_SRL  = 4'd10;
    localparam logic [3:0] CTR_SRA  = 4'd11;
    localparam logic [3:0] CTR_NOR  = 4'd12;
    localparam logic [3:0] CTR_MDU  = 4'd13;
    localparam logic [3:0] CTR_NOP  = 4'd15;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_OR  = 2'b10;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] ctr;
        logic       illegal;
        logic       md;
        logic       md_div;
        logic       md_signed;
        logic       mf_hi;
        logic       mf_lo;
    } dec_t;

    function automatic dec_t decode(input logic [2:0] alu_op, input logic [5:0] fn);
        dec_t d;
        d     = '0;
        d.ctr = CTR_NOP;
        if (alu_op[2]) begin
            case (fn)
                FN_SLL:   d.ctr = CTR_SLL;
                FN_SRL:   d.ctr = CTR_SRL;
                FN_SRA:   d.ctr = CTR_SRA;
                FN_ADD:   d.ctr = CTR_ADD;
                FN_ADDU:  d.ctr = CTR_ADDU;
                FN_SUB:   d.ctr = CTR_SUB;
                FN_SUBU:  d.ctr = CTR_SUBU;
                FN_AND:   d.ctr = CTR_AND;
                FN_OR:    d.ctr = CTR_OR;
                FN_XOR:   d.ctr = CTR_XOR;
                FN_NOR:   d.ctr = CTR_NOR;
                FN_SLT:   d.ctr = CTR_SLT;
                FN_SLTU:  d.ctr = CTR_SLTU;
                FN_MFHI:  d.mf_hi = 1'b1;
                FN_MFLO:  d.mf_lo = 1'b1;
                FN_MULT:  begin d.ctr = CTR_MDU; d.md = 1'b1; d.md_signed = 1'b1; end
                FN_MULTU: begin d.ctr = CTR_MDU; d.md = 1'b1; end
`ifdef ALU_SEQ_DIV_EN
                FN_DIV:   begin d.ctr = CTR_MDU; d.md = 1'b1; d.md_div = 1'b1; d.md_signed = 1'b1; end
                FN_DIVU:  begin d.ctr = CTR_MDU; d.md = 1'b1; d.md_div = 1'b1; end
`endif
                default:  d.illegal = 1'b1;
            endcase
        end else begin
            case (alu_op[1:0])
                ALUOP_ADD: d.ctr = CTR_ADD;
                ALUOP_SUB: d.ctr = CTR_SUB;
                ALUOP_OR:  d.ctr = CTR_OR;
                default:   d.ctr = CTR_AND;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_mdu.sv
// Iterative shift-add multiplier / restoring divider working on operand magnitudes.
// Divider datapath exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_mdu
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             kill,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] p_r;
    logic [WIDTH-1:0]   d_r;
    logic               neg_a_r;
    logic               neg_b_r;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_nxt_s;
    logic [2*WIDTH-1:0] step_nxt_s;
    logic [2*WIDTH-1:0] prod_s;

    assign neg_a_s = is_signed & a[WIDTH-1];
    assign neg_b_s = is_signed & b[WIDTH-1];
    assign mag_a_s = neg_a_s ? -a : a;
    assign mag_b_s = neg_b_s ? -b : b;

    // Shift-add step: upper half accumulates, multiplier shifts out of the low end
    always_comb begin
        sum_s = {1'b0, p_r[2*WIDTH-1:WIDTH]} + {1'b0, d_r};
        if (p_r[0]) begin
            mul_nxt_s = {sum_s, p_r[WIDTH-1:1]};
        end else begin
            mul_nxt_s = {1'b0, p_r[2*WIDTH-1:1]};
        end
    end

`ifdef ALU_SEQ_DIV_EN
    logic               div_r;
    logic               b_zero_r;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] div_nxt_s;

    // Restoring step: remainder in the upper half, quotient bits fill the lower half
    always_comb begin
        shifted_s = p_r[2*WIDTH-1:WIDTH-1];
        diff_s    = shifted_s - {1'b0, d_r};
        if (diff_s[WIDTH]) begin
            div_nxt_s = {shifted_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b0};
        end else begin
            div_nxt_s = {diff_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b1};
        end
    end

    assign step_nxt_s = div_r ? div_nxt_s : mul_nxt_s;

    // Divide-mode flags captured at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (start) begin
            div_r    <= is_div;
            b_zero_r <= (b == '0);
        end else if (kill) begin
            div_r    <= 1'b0;
            b_zero_r <= 1'b0;
        end
    end
`else
    logic unused_div_s;
    assign unused_div_s = is_div;
    assign step_nxt_s   = mul_nxt_s;
`endif

    // Operand load on start, iteration while the controller is in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r     <= '0;
            d_r     <= '0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
        end else if (start) begin
`ifdef ALU_SEQ_DIV_EN
            if (is_div) begin
                p_r <= {{WIDTH{1'b0}}, mag_a_s};
                d_r <= mag_b_s;
            end else begin
                p_r <= {{WIDTH{1'b0}}, mag_b_s};
                d_r <= mag_a_s;
            end
`else
            p_r <= {{WIDTH{1'b0}}, mag_b_s};
            d_r <= mag_a_s;
`endif
            neg_a_r <= neg_a_s;
            neg_b_r <= neg_b_s;
        end else if (kill) begin
            p_r     <= '0;
            d_r     <= '0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
        end else if (step) begin
            p_r <= step_nxt_s;
        end
    end

    // Sign fix; remainder follows the dividend, divide-by-zero forces an all-ones quotient
    always_comb begin
        prod_s = (neg_a_r ^ neg_b_r) ? -p_r : p_r;
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        if (div_r) begin
            res_hi = neg_a_r ? -p_r[2*WIDTH-1:WIDTH] : p_r[2*WIDTH-1:WIDTH];
            if (b_zero_r) begin
                res_lo = '1;
            end else if (neg_a_r ^ neg_b_r) begin
                res_lo = -p_r[WIDTH-1:0];
            end else begin
                res_lo = p_r[WIDTH-1:0];
            end
        end else begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
        end
`endif
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// DLX ALU control decode plus HI/LO ownership and the multi-cycle mul/div sequencer FSM.
// Optional feature macro: ALU_SEQ_DIV_EN (enables DIV/DIVU; otherwise they decode as illegal).
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             kill_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [CTR_W-1:0] alu_ctr,
    output logic             illegal_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    dec_t             dec_s;
    logic             accept_s;
    logic             start_s;
    logic             kill_s;
    logic             last_s;
    logic [WIDTH-1:0] md_hi_s;
    logic [WIDTH-1:0] md_lo_s;

    assign dec_s    = decode(ALUOp, func);
    assign ready_o  = (state_r == ST_IDLE);
    assign accept_s = valid_i && ready_o;
    assign start_s  = accept_s && dec_s.md;
    assign kill_s   = kill_i && !ready_o;
    assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

    alu_seq_mdu #(.WIDTH(WIDTH)) u_mdu (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .step      (state_r == ST_RUN),
        .kill      (kill_s),
        .is_div    (dec_s.md_div),
        .is_signed (dec_s.md_signed),
        .a         (a_i),
        .b         (b_i),
        .res_hi    (md_hi_s),
        .res_lo    (md_lo_s)
    );

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (kill_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and RUN-cycle counter (cleared whenever not iterating)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Registered outputs; a killed FIX leaves HI/LO untouched and raises no done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctr   <= CTR_W'(CTR_NOP);
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            result_o  <= '0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else if (accept_s) begin
            alu_ctr   <= CTR_W'(dec_s.ctr);
            done_o    <= !dec_s.md;
            illegal_o <= dec_s.illegal;
            if (dec_s.mf_hi) begin
                result_o <= hi_o;
            end else if (dec_s.mf_lo) begin
                result_o <= lo_o;
            end else begin
                result_o <= '0;
            end
        end else if ((state_r == ST_FIX) && !kill_i) begin
            done_o    <= 1'b1;
            illegal_o <= 1'b0;
            result_o  <= '0;
            hi_o      <= md_hi_s;
            lo_o      <= md_lo_s;
        end else begin
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            result_o  <= '0;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed cases plus random ops against an arithmetic reference.
module tb_alu_seq_ctrl;

    localparam int W = 32;

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic         kill_i = 1'b0;
    logic [2:0]   ALUOp = 3'd0;
    logic [5:0]   func = 6'd0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         ready_o, done_o, illegal_o;
    logic [3:0]   alu_ctr;
    logic [W-1:0] result_o, hi_o, lo_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int           cyc;
        logic [3:0]   ctr;
        logic         ill;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_seq_ctrl #(.WIDTH(W), .CTR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUOp(ALUOp), .func(func),
        .a_i(a_i), .b_i(b_i), .kill_i(kill_i), .ready_o(ready_o), .done_o(done_o),
        .alu_ctr(alu_ctr), .illegal_o(illegal_o), .result_o(result_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what the op means architecturally, with HI/LO held as plain variables
    task automatic model(input logic [2:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output exp_t e, output bit md);
        longint       sa, sb_v, q, r;
        logic [63:0]  p;
        e.ctr = 4'd15; e.ill = 1'b0; e.res = '0; e.cyc = 0; md = 1'b0;
        sa = $signed(a);
        sb_v = $signed(b);
        if (op[2]) begin
            case (fn)
                6'd0:  e.ctr = 4'd5;
                6'd2:  e.ctr = 4'd10;
                6'd3:  e.ctr = 4'd11;
                6'd32: e.ctr = 4'd2;
                6'd33: e.ctr = 4'd8;
                6'd34: e.ctr = 4'd6;
                6'd35: e.ctr = 4'd9;
                6'd36: e.ctr = 4'd0;
                6'd37: e.ctr = 4'd1;
                6'd38: e.ctr = 4'd4;
                6'd39: e.ctr = 4'd12;
                6'd42: e.ctr = 4'd3;
                6'd43: e.ctr = 4'd7;
                6'd16: e.res = m_hi;
                6'd18: e.res = m_lo;
                6'd24: begin md = 1'b1; p = sa * sb_v; {m_hi, m_lo} = p; end
                6'd25: begin md = 1'b1; p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
                6'd26, 6'd27: begin
                    if (!DIV_EN) begin
                        e.ill = 1'b1;
                    end else begin
                        md = 1'b1;
                        if (b == '0) begin
                            m_lo = '1; m_hi = a;
                        end else if (fn == 6'd26) begin
                            q = sa / sb_v; r = sa % sb_v;
                            p = q; m_lo = p[31:0];
                            p = r; m_hi = p[31:0];
                        end else begin
                            m_lo = a / b; m_hi = a % b;
                        end
                    end
                end
                default: e.ill = 1'b1;
            endcase
        end else begin
            case (op[1:0])
                2'd0: e.ctr = 4'd2;
                2'd1: e.ctr = 4'd6;
                2'd2: e.ctr = 4'd1;
                default: e.ctr = 4'd0;
            endcase
        end
        if (md) e.ctr = 4'd13;
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Presents one op in the current cycle; returns one cycle later (#1 after the accept edge)
    task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit no_expect);
        exp_t e;
        bit   md;
        wait_ready();
        check("issue_ready", ready_o, 1);
        valid_i = 1'b1; ALUOp = op; func = fn; a_i = a; b_i = b;
        if (!no_expect) begin
            model(op, fn, a, b, e, md);
            e.cyc = cyc + (md ? W + 2 : 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ready"}, ready_o, 1);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_illegal"}, illegal_o, 0);
        check({tag, "_result"}, result_o, 0);
        check({tag, "_alu_ctr"}, alu_ctr, 15);
        check({tag, "_hi"}, hi_o, 0);
        check({tag, "_lo"}, lo_o, 0);
    endtask

    // Monitor: every done_o must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done_o=1 expected no completion (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("alu_ctr", alu_ctr, mon_e.ctr);
                check("illegal", illegal_o, mon_e.ill);
                check("result", result_o, mon_e.res);
                check("hi", hi_o, mon_e.hi);
                check("lo", lo_o, mon_e.lo);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int n;
        int sel;
        logic [2:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] a, b;
        int           fns[19] = '{0, 2, 3, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 16, 18, 24, 25, 26, 27};
        logic [W-1:0] corners[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        reset_check("reset");

        issue(3'b100, 6'd42, 32'd5, 32'd9, 1'b0);
        issue(3'b001, 6'd0, 32'd5, 32'd9, 1'b0);

        k = cyc;
        issue(3'b100, 6'd24, 32'hFFFFFFFD, 32'd7, 1'b0);
        check("mult_busy_c1", ready_o, 0);
        while (cyc < k + W + 1) begin @(posedge clk); #1; end
        check("mult_busy_last", ready_o, 0);
        wait_ready();
        check("mult_ready_cycle", cyc, k + W + 2);

        issue(3'b100, 6'd27, 32'd100, 32'd7, 1'b0);
        issue(3'b100, 6'd26, 32'hFFFFFFF9, 32'd2, 1'b0);
        issue(3'b100, 6'd16, 32'd0, 32'd0, 1'b0);
        issue(3'b100, 6'd26, 32'd5, 32'd0, 1'b0);
        issue(3'b100, 6'd26, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(3'b100, 6'd18, 32'd0, 32'd0, 1'b0);

        k = cyc;
        issue(3'b100, 6'd25, $urandom, $urandom, 1'b1);
        while (cyc < k + 10) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        check("kill_ready", ready_o, 1);
        check("kill_hi", hi_o, m_hi);
        check("kill_lo", lo_o, m_lo);
        repeat (W + 4) @(posedge clk);
        #1;

        kill_i = 1'b1;
        issue(3'b100, 6'd25, 32'hFFFFFFFF, 32'd3, 1'b0);
        kill_i = 1'b0;

        issue(3'b100, 6'd1, 32'd0, 32'd0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                op = 3'($urandom_range(0, 3));
                fn = 6'($urandom_range(0, 63));
            end else if (sel == 2) begin
                op = 3'b100;
                fn = 6'($urandom_range(0, 63));
            end else begin
                op = 3'b100;
                fn = 6'(fns[$urandom_range(0, 18)]);
            end
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue(op, fn, a, b, 1'b0);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", sb.size(), 0);

        issue(3'b100, 6'd24, $urandom, $urandom, 1'b1);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        reset_check("midrun_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        reset_check("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Parametrised ALU control unit with an integrated iterative multiply/divide sequencer for the DLX execute stage. Decodes `ALUOp`/`func` into a registered 4-bit ALU control code for single-cycle ops. Owns HI/LO and runs MULT/MULTU/DIV/DIVU over WIDTH cycles behind a valid/ready handshake. The hazard unit stalls issue while `ready_o` is low.

## Interface
- `WIDTH`, 32: operand, HI and LO width, ≥ 4.
- `CTR_W`, 4: ALU control code width, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `valid_i`  in  1  op presented; accepted when `valid_i && ready_o`.
- `ALUOp`  in  3  bit 2 = R-type (decode `func`); 3'b000 ADD, 001 SUB, 010 OR, 011 AND.
- `func`  in  6  R-type function field.
- `a_i`, `b_i`  in  WIDTH  operands, sampled on accept.
- `kill_i`  in  1  synchronous abort of an in-flight multi-cycle op.
- `ready_o`  out  1  high when FSM is IDLE (combinational from state).
- `done_o`  out  1  one-cycle completion pulse.
- `alu_ctr`  out  CTR_W  registered control code.
- `illegal_o`  out  1  registered, valid with `done_o`.
- `result_o`  out  WIDTH  MFHI/MFLO data, valid with `done_o`, else 0.
- `hi_o`, `lo_o`  out  WIDTH  architectural HI/LO.

## Operation
- Codes: AND 0, OR 1, ADD 2, SLT 3, XOR 4, SLL 5, SUB 6, SLTU 7, ADDU 8, SUBU 9, SRL 10, SRA 11, NOR 12, MDU 13, NOP 15.
- `func` decode: 0 SLL, 2 SRL, 3 SRA, 32 ADD, 33 ADDU, 34 SUB, 35 SUBU, 36 AND, 37 OR, 38 XOR, 39 NOR, 42 SLT, 43 SLTU.
- 16 MFHI, 18 MFLO: `alu_ctr` = NOP, `result_o` = HI/LO.
- 24 MULT, 25 MULTU, 26 DIV, 27 DIVU: `alu_ctr` = MDU.
- Any other `func`, or `ALUOp` 3'b0xx outside the four codes above: NOP with `illegal_o` = 1.
- FSM states IDLE, RUN, FIX.
  - IDLE → RUN on accepting a mul/div.
  - RUN lasts exactly WIDTH cycles, counted by a log2(WIDTH)+1-bit counter.
  - RUN → FIX, then FIX → IDLE.
- Signed ops work on magnitudes. FIX applies the signs, writes HI/LO and sets `done_o`.
- Multiply: shift-add, 2·WIDTH-bit product, HI = upper half, LO = lower half.
- Divide: restoring, LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
- Divide by zero: still takes the full latency. LO = all ones, HI = dividend.
- DIV MIN/−1: LO = MIN, HI = 0.
- `kill_i` is honoured in RUN/FIX only and forces IDLE next cycle: HI/LO unchanged, no `done_o`. If `kill_i` arrives with a new accept in IDLE, the accept wins.
- Reset: state IDLE, HI = LO = 0, `done_o` = 0, `illegal_o` = 0, `result_o` = 0, `alu_ctr` = NOP (15), `ready_o` = 1.

## Timing
- Single-cycle op accepted in cycle 0: `alu_ctr`, `illegal_o`, `result_o` and `done_o` are valid in cycle 1. Back-to-back accepts are allowed.
- Mul/div accepted in cycle 0:
  - `ready_o` low in cycles 1..WIDTH+1.
  - `done_o` and new HI/LO in cycle WIDTH+2.
  - `ready_o` high again in cycle WIDTH+2, so a new accept is possible there.
- `alu_ctr` holds its last value until the next accept. `done_o` is never high for two consecutive cycles from a single op.
- Reset mid-RUN: immediately returns to the reset state.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIV/DIVU are implemented as above.
- `ALU_SEQ_DIV_EN` undefined:
  - 26/27 decode as illegal: NOP, single-cycle, `illegal_o` = 1, HI/LO unchanged.
  - Divider logic is removed and RUN serves multiply only.

## Structure
- Package `alu_seq_pkg`: control-code localparams, FSM state enum, `func` and `ALUOp` constants.
- Sub-module `alu_seq_mdu`: iterative mul/div datapath (shift registers, adder/subtractor, sign fix) with start/kill inputs. The top level holds decode, FSM, handshake and HI/LO.

## Test plan
- Reset, then accept R-type with `func` = 42: `alu_ctr` = 3 and `done_o` = 1 in cycle 1. `ALUOp` = 001 next cycle: `alu_ctr` = 6.
- MULT, a = −3, b = 7, WIDTH = 32: `ready_o` low in cycles 1–33, `done_o` in cycle 34, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIVU 100/7: LO = 14, HI = 2. DIV −7/2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then MFHI: `result_o` = 0xFFFFFFFF.
- DIV 5/0: after full latency, LO = 0xFFFFFFFF, HI = 5. Without `ALU_SEQ_DIV_EN`: `illegal_o` = 1 in cycle 1, HI/LO unchanged.
- MULTU with `kill_i` in cycle 10: `ready_o` high in cycle 11, no `done_o`, HI/LO retain prior values.
- `func` = 1 (undefined): `alu_ctr` = 15, `illegal_o` = 1. Assert `rst_n` low mid-RUN: all outputs return to reset values.
